// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-length burst protection,
// locked-transfer hold and error-driven burst abort.
module ahb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   HCLK,
  input  logic                   HRST,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [3:0]             HMASTER,
  output logic                   HMASTLOCK
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [1:0] RESP_OKAY = 2'd0;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    BURST = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   burst_len;
  logic [IDX_W-1:0]   ptr, ptr_nxt;
  logic [IDX_W-1:0]   gidx, gidx_nxt;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_win;
  logic               rr_found;
  logic               accepted;
  logic               lock_hold;
  logic [3:0]         hmaster_nxt;
  logic               hmastlock_nxt;
  int unsigned        cand;

  assign owner = HMASTER[IDX_W-1:0];

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst
  always_comb begin
    burst_len = '0;
    unique case (HBURST)
      3'd2, 3'd3: burst_len = CNT_W'(3);
      3'd4, 3'd5: burst_len = CNT_W'(7);
      3'd6, 3'd7: burst_len = CNT_W'(15);
      default:    burst_len = '0;
    endcase
  end

  // First requester after the last winner; default master when nobody asks
  always_comb begin
    rr_found = 1'b0;
    rr_win   = IDX_W'(DEFAULT_MASTER);
    cand     = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(ptr) + k) % NUM_MASTERS;
      if (!rr_found && HBUSREQ[IDX_W'(cand)]) begin
        rr_found = 1'b1;
        rr_win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    gidx_nxt      = gidx;
    hmaster_nxt   = HMASTER;
    hmastlock_nxt = HMASTLOCK;
    accepted      = HREADY && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
    lock_hold     = HLOCK[owner] && HBUSREQ[owner];

    if (HREADY) begin
      hmaster_nxt   = 4'(gidx);
      hmastlock_nxt = HLOCK[gidx];

      // A NONSEQ always restarts the count, which also ends a burst early
      if (accepted && HTRANS == TR_NONSEQ) begin
        cnt_nxt = burst_len;
      end else if (accepted && cnt != '0) begin
        cnt_nxt = cnt - CNT_W'(1);
      end

      unique case (state)
        LOCK: begin
          if (!HLOCK[owner]) begin
            state_nxt = (cnt_nxt != '0) ? BURST : ARB;
          end
        end
        default: begin
          if (lock_hold) begin
            state_nxt = LOCK;
          end else if (cnt_nxt != '0) begin
            state_nxt = BURST;
          end else begin
            state_nxt = ARB;
          end
        end
      endcase

      if (state_nxt == LOCK) begin
        gidx_nxt = owner;
      end else if (state_nxt == ARB) begin
        gidx_nxt = rr_win;
        if (rr_found) begin
          ptr_nxt = rr_win;
        end
      end
    end else if (HRESP != RESP_OKAY) begin
      // First cycle of a two-cycle error response aborts a fixed burst
      cnt_nxt = '0;
      if (state == BURST) begin
        state_nxt = ARB;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRST) begin
    if (HRST) begin
      state     <= ARB;
      cnt       <= '0;
      ptr       <= IDX_W'(DEFAULT_MASTER);
      gidx      <= IDX_W'(DEFAULT_MASTER);
      HGRANT    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      HMASTER   <= 4'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      gidx      <= gidx_nxt;
      HGRANT    <= NUM_MASTERS'(1) << gidx_nxt;
      HMASTER   <= hmaster_nxt;
      HMASTLOCK <= hmastlock_nxt;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round-robin, fixed bursts, lock,
// error abort and asynchronous reset in the middle of a burst.
module tb_ahb_arbiter;

  localparam int unsigned N = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  logic         HCLK = 1'b0;
  logic         HRST;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic [N-1:0] HGRANT;
  logic [3:0]   HMASTER;
  logic         HMASTLOCK;

  int tests = 0;
  int fails = 0;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(0)) dut (
    .HCLK      (HCLK),
    .HRST      (HRST),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK)
  );

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HBUSREQ = '0;
    HLOCK   = '0;
    HTRANS  = IDLE;
    HBURST  = 3'd0;
    HREADY  = 1'b1;
    HRESP   = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRST = 1'b1;
    step();
    step();
    HRST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    HRST = 1'b1;
    step();
    tests++;
    if (HGRANT !== 4'b0001 || HMASTER !== 4'd0 || HMASTLOCK !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got grant=%b master=%0d lock=%b, expected 0001/0/0",
               HGRANT, HMASTER, HMASTLOCK);
    end
    HRST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (HGRANT !== 4'b0001 || HMASTER !== 4'd0 || HMASTLOCK !== 1'b0) begin
        fails++;
        $display("FAIL idle_default[%0d]: got grant=%b master=%0d lock=%b, expected 0001/0/0",
                 i, HGRANT, HMASTER, HMASTLOCK);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg [0:4];
    logic [3:0] em [0:4];
    eg = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    em = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    do_reset();
    HBUSREQ = 4'b1111;
    HTRANS  = NONSEQ;
    HBURST  = 3'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (HGRANT !== eg[i] || HMASTER !== em[i]) begin
        fails++;
        $display("FAIL rr[%0d]: got grant=%b master=%0d, expected grant=%b master=%0d",
                 i, HGRANT, HMASTER, eg[i], em[i]);
      end
    end
    HREADY = 1'b0;
    step();
    tests++;
    if (HGRANT !== 4'b0010 || HMASTER !== 4'd0) begin
      fails++;
      $display("FAIL rr_stall: got grant=%b master=%0d, expected 0010/0", HGRANT, HMASTER);
    end
    HREADY = 1'b1;
    step();
    tests++;
    if (HGRANT !== 4'b0100 || HMASTER !== 4'd1) begin
      fails++;
      $display("FAIL rr_resume: got grant=%b master=%0d, expected 0100/1", HGRANT, HMASTER);
    end
  endtask

  task automatic test_fixed_burst();
    logic [3:0] t_req [0:8];
    logic [1:0] t_tr  [0:8];
    logic       t_rdy [0:8];
    logic [3:0] eg    [0:8];
    logic [3:0] em    [0:8];
    t_req = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    t_tr  = '{IDLE, IDLE, NONSEQ, SEQ, BUSY, SEQ, SEQ, SEQ, SEQ};
    t_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eg    = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    em    = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    do_reset();
    HBURST = 3'd3;
    for (int i = 0; i < 9; i++) begin
      HBUSREQ = t_req[i];
      HTRANS  = t_tr[i];
      HREADY  = t_rdy[i];
      step();
      tests++;
      if (HGRANT !== eg[i] || HMASTER !== em[i]) begin
        fails++;
        $display("FAIL burst[%0d]: got grant=%b master=%0d, expected grant=%b master=%0d",
                 i, HGRANT, HMASTER, eg[i], em[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    HBUSREQ = 4'b0100;
    step();
    step();
    HBUSREQ = 4'b1111;
    HTRANS  = NONSEQ;
    HBURST  = 3'd3;
    step();
    HTRANS = SEQ;
    step();
    tests++;
    if (HGRANT !== 4'b0100 || HMASTER !== 4'd2) begin
      fails++;
      $display("FAIL pre_reset: got grant=%b master=%0d, expected 0100/2", HGRANT, HMASTER);
    end
    #2;
    HRST = 1'b1;
    #1;
    tests++;
    if (HGRANT !== 4'b0001 || HMASTER !== 4'd0 || HMASTLOCK !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got grant=%b master=%0d lock=%b, expected 0001/0/0",
               HGRANT, HMASTER, HMASTLOCK);
    end
    step();
    HTRANS = IDLE;
    HRST   = 1'b0;
    step();
    tests++;
    if (HGRANT !== 4'b0010 || HMASTER !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_arb: got grant=%b master=%0d, expected 0010/0", HGRANT, HMASTER);
    end
  endtask

  task automatic test_lock();
    do_reset();
    HBUSREQ = 4'b0010;
    HLOCK   = 4'b0010;
    HTRANS  = NONSEQ;
    HBURST  = 3'd1;
    step();
    tests++;
    if (HGRANT !== 4'b0010 || HMASTER !== 4'd0 || HMASTLOCK !== 1'b0) begin
      fails++;
      $display("FAIL lock_grant: got grant=%b master=%0d lock=%b, expected 0010/0/0",
               HGRANT, HMASTER, HMASTLOCK);
    end
    step();
    HBUSREQ = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (HGRANT !== 4'b0010 || HMASTER !== 4'd1 || HMASTLOCK !== 1'b1) begin
        fails++;
        $display("FAIL lock_hold[%0d]: got grant=%b master=%0d lock=%b, expected 0010/1/1",
                 i, HGRANT, HMASTER, HMASTLOCK);
      end
    end
    HLOCK = 4'b0000;
    step();
    tests++;
    if (HGRANT !== 4'b1000 || HMASTER !== 4'd1 || HMASTLOCK !== 1'b0) begin
      fails++;
      $display("FAIL lock_release: got grant=%b master=%0d lock=%b, expected 1000/1/0",
               HGRANT, HMASTER, HMASTLOCK);
    end
    step();
    tests++;
    if (HGRANT !== 4'b0010 || HMASTER !== 4'd3) begin
      fails++;
      $display("FAIL lock_after: got grant=%b master=%0d, expected 0010/3", HGRANT, HMASTER);
    end
  endtask

  task automatic test_error_abort();
    do_reset();
    HBUSREQ = 4'b0001;
    HTRANS  = NONSEQ;
    HBURST  = 3'd5;
    step();
    HBUSREQ = 4'b0101;
    HTRANS  = SEQ;
    step();
    tests++;
    if (HGRANT !== 4'b0001 || HMASTER !== 4'd0) begin
      fails++;
      $display("FAIL err_burst_hold: got grant=%b master=%0d, expected 0001/0", HGRANT, HMASTER);
    end
    HREADY = 1'b0;
    HRESP  = 2'd1;
    step();
    tests++;
    if (HGRANT !== 4'b0001 || HMASTER !== 4'd0) begin
      fails++;
      $display("FAIL err_first: got grant=%b master=%0d, expected 0001/0", HGRANT, HMASTER);
    end
    HREADY = 1'b1;
    HTRANS = IDLE;
    step();
    tests++;
    if (HGRANT !== 4'b0100 || HMASTER !== 4'd0) begin
      fails++;
      $display("FAIL err_rearb: got grant=%b master=%0d, expected 0100/0", HGRANT, HMASTER);
    end
    HRESP = 2'd0;
    step();
    tests++;
    if (HGRANT !== 4'b0001 || HMASTER !== 4'd2) begin
      fails++;
      $display("FAIL err_after: got grant=%b master=%0d, expected 0001/2", HGRANT, HMASTER);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_burst();
    test_reset_mid_burst();
    test_lock();
    test_error_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, master granted when no requests are pending.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all state changes on the HCLK rising edge.
REQ-004 SHALL have port HCLK  input  1  bus clock.
REQ-005 SHALL have port HRST  input  1  asynchronous active-high reset.
REQ-006 SHALL have port HBUSREQ  input  NUM_MASTERS  per-master bus request.
REQ-007 SHALL have port HLOCK  input  NUM_MASTERS  per-master locked-transfer request.
REQ-008 SHALL have port HTRANS  input  2  current address-phase transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 SHALL have port HBURST  input  3  current burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-010 SHALL have port HREADY  input  1  transfer-complete, shared bus.
REQ-011 SHALL have port HRESP  input  2  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3).
REQ-012 SHALL have port HGRANT  output  NUM_MASTERS  one-hot grant, registered.
REQ-013 SHALL have port HMASTER  output  4  index of master owning the address phase, registered.
REQ-014 SHALL have port HMASTLOCK  output  1  current address phase is locked, registered.

Function
REQ-015 "Accepted beat" SHALL mean a rising edge with HREADY=1 and HTRANS in {NONSEQ, SEQ}.
REQ-016 FSM states SHALL be ARB (re-arbitration allowed), BURST (fixed-length burst in progress), LOCK (owner holds lock).
REQ-017 When HREADY=0, HGRANT, HMASTER, HMASTLOCK, FSM state and beat counter SHALL hold.
REQ-018 In ARB with HREADY=1, next HGRANT SHALL be the first requester in round-robin order starting at (last winner+1) mod NUM_MASTERS; if no HBUSREQ is set, HGRANT SHALL select DEFAULT_MASTER.
REQ-019 The round-robin pointer SHALL update only when a requesting master wins; a DEFAULT_MASTER grant with no requests SHALL NOT move it.
REQ-020 HMASTER and HMASTLOCK SHALL load index(HGRANT) and HLOCK[index(HGRANT)] on every edge with HREADY=1 (one-cycle grant-to-ownership latency).
REQ-021 On an accepted NONSEQ with HBURST in WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, a 4-bit beat counter SHALL load 3, 7, 15 respectively and FSM SHALL enter BURST.
REQ-022 In BURST, each accepted SEQ SHALL decrement the counter; on reaching 0 FSM SHALL return to ARB, and arbitration on that same edge SHALL be allowed.
REQ-023 BUSY and IDLE beats SHALL NOT change the counter.
REQ-024 SINGLE and INCR bursts SHALL NOT enter BURST; grant may move on any HREADY=1 edge.
REQ-025 In ARB or BURST, if HLOCK[HMASTER]=1 and HBUSREQ[HMASTER]=1, FSM SHALL enter LOCK and HGRANT SHALL stay on HMASTER.
REQ-026 LOCK SHALL exit to ARB on the first HREADY=1 edge where HLOCK[HMASTER]=0, unless a fixed burst is still counting, in which case exit SHALL go to BURST.
REQ-027 HRESP other than OKAY with HREADY=0 SHALL clear the counter and force FSM to ARB on the next edge, overriding BURST (not LOCK).
REQ-028 HGRANT SHALL always be exactly one-hot; HMASTER SHALL always be < NUM_MASTERS.
REQ-029 A simultaneous NONSEQ for a new burst and final SEQ of the previous burst is not possible on one edge; a NONSEQ in BURST SHALL reload the counter (early termination).

Reset
REQ-030 While HRST=1: HGRANT = one-hot DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, FSM = ARB, counter = 0, round-robin pointer = DEFAULT_MASTER.
REQ-031 Reset asserted mid-burst or mid-lock SHALL immediately restore REQ-030 values; first arbitration SHALL occur on the first HREADY=1 edge after HRST falls.

Verification
REQ-032 Reset, HBUSREQ=0, HREADY=1 for 5 cycles -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 throughout.
REQ-033 HBUSREQ=1111 held, all SINGLE NONSEQ, HREADY=1 -> HGRANT sequence 0010,0100,1000,0001; HMASTER trails by one cycle.
REQ-034 Master 2 granted, issues INCR4 NONSEQ + 3 SEQ with one BUSY and HREADY=0 for 2 cycles, HBUSREQ=1111 -> HGRANT stays 0100 until third SEQ accepted, then moves to 1000.
REQ-035 Master 1 HLOCK=1 and HBUSREQ=1 for 6 beats with master 3 requesting -> HGRANT=0010, HMASTLOCK=1 all 6 beats; grant moves to 1000 on first HREADY=1 edge after HLOCK[1]=0.
REQ-036 Master 0 in INCR8 after 2 beats, two-cycle ERROR response (HREADY=0 then 1) -> counter 0, FSM ARB, grant moves to next requester on that HREADY=1 edge.
REQ-037 HRST pulsed during REQ-034 burst -> outputs return to REQ-030 values asynchronously; next arbitration starts from DEFAULT_MASTER+1.
